// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multicycle main control FSM and its opcode decoder.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ADDI  = 3'b001;
    localparam logic [2:0] ALUOP_SLTIU = 3'b010;
    localparam logic [2:0] ALUOP_BEQ   = 3'b011;
    localparam logic [2:0] ALUOP_LUI   = 3'b100;
    localparam logic [2:0] ALUOP_ORI   = 3'b101;
    localparam logic [2:0] ALUOP_BNE   = 3'b110;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_BRANCH  = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_e;

endpackage

// File: rtl/mc_op_decode.sv
// Purely combinational opcode decoder: ALUOp, operand/destination selects and instruction class.
module mc_op_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    i_op,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_alu_src,
    output logic               o_reg_dst,
    output logic               o_mem_to_reg,
    output logic               o_br_ne,
    output instr_class_e       o_cls
);

    always_comb begin
        // NOTE: every output is given a default first, so no decode path can infer a latch.
        o_alu_op     = ALUOP_ADDI;
        o_alu_src    = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_br_ne      = 1'b0;
        o_cls        = CLS_ILLEGAL;
        case (i_op)
            OP_RTYPE: begin
                o_alu_op  = ALUOP_RTYPE;
                o_reg_dst = 1'b1;
                o_cls     = CLS_ALU;
            end
            OP_ADDI: begin
                o_alu_op  = ALUOP_ADDI;
                o_alu_src = 1'b1;
                o_cls     = CLS_ALU;
            end
            OP_SLTIU: begin
                o_alu_op  = ALUOP_SLTIU;
                o_alu_src = 1'b1;
                o_cls     = CLS_ALU;
            end
            OP_LUI: begin
                o_alu_op  = ALUOP_LUI;
                o_alu_src = 1'b1;
                o_cls     = CLS_ALU;
            end
            OP_ORI: begin
                o_alu_op  = ALUOP_ORI;
                o_alu_src = 1'b1;
                o_cls     = CLS_ALU;
            end
            OP_BEQ: begin
                o_alu_op = ALUOP_BEQ;
                o_cls    = CLS_BRANCH;
            end
            OP_BNE: begin
                o_alu_op = ALUOP_BNE;
                o_br_ne  = 1'b1;
                o_cls    = CLS_BRANCH;
            end
            OP_LW: begin
                o_alu_op     = ALUOP_ADDI;
                o_alu_src    = 1'b1;
                o_mem_to_reg = 1'b1;
                o_cls        = CLS_LOAD;
            end
            OP_SW: begin
                o_alu_op  = ALUOP_ADDI;
                o_alu_src = 1'b1;
                o_cls     = CLS_STORE;
            end
            OP_J: begin
                o_cls = CLS_JUMP;
            end
            default: begin
                o_cls = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Multicycle main control FSM (IF/ID/EX/MEM/WB) with imem/dmem ready stalls.
// Optional performance counters are built when MC_CTRL_PERF_CNT_EN is defined.
module multicycle_main_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic               imem_ready_i,
    input  logic               dmem_ready_i,
    input  logic               zero_i,
    output logic               imem_read_o,
    output logic               IR_write_o,
    output logic               PC_write_o,
    output logic [1:0]         PC_src_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic               ALUSrc_o,
    output logic               RegDst_o,
    output logic               RegWrite_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               MemtoReg_o,
    output logic               illegal_o,
    output logic [2:0]         state_o
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_cnt_o,
    output logic [31:0]        instret_cnt_o
`endif
);

    state_e            r_state;
    state_e            w_next;
    logic [OP_W-1:0]   r_op_q;
    logic [OP_W-1:0]   w_dec_op;

    logic [ALUOP_W-1:0] w_dec_alu_op;
    logic               w_dec_alu_src;
    logic               w_dec_reg_dst;
    logic               w_dec_mem_to_reg;
    logic               w_dec_br_ne;
    instr_class_e       w_dec_cls;

    logic               w_imem_read;
    logic               w_ir_write;
    logic               w_pc_write;
    logic [1:0]         w_pc_src;
    logic [ALUOP_W-1:0] w_alu_op;
    logic               w_alu_src;
    logic               w_reg_dst;
    logic               w_reg_write;
    logic               w_mem_read;
    logic               w_mem_write;
    logic               w_mem_to_reg;
    logic               w_illegal;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IF;
            r_op_q  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID) begin
                r_op_q <= op_i;
            end
        end
    end

    // In ID the opcode is not yet captured, so the single decoder looks at the IR directly.
    assign w_dec_op = (r_state == S_ID) ? op_i : r_op_q;

    mc_op_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_op_decode (
        .i_op         (w_dec_op),
        .o_alu_op     (w_dec_alu_op),
        .o_alu_src    (w_dec_alu_src),
        .o_reg_dst    (w_dec_reg_dst),
        .o_mem_to_reg (w_dec_mem_to_reg),
        .o_br_ne      (w_dec_br_ne),
        .o_cls        (w_dec_cls)
    );

    always_comb begin
        w_next       = r_state;
        w_imem_read  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = PC_SRC_SEQ;
        w_alu_op     = ALUOP_ADDI;
        w_alu_src    = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_IF: begin
                w_imem_read = 1'b1;
                if (imem_ready_i) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_pc_src   = PC_SRC_SEQ;
                    w_next     = S_ID;
                end
            end
            S_ID: begin
                case (w_dec_cls)
                    CLS_JUMP: begin
                        w_pc_write = 1'b1;
                        w_pc_src   = PC_SRC_JUMP;
                        w_next     = S_IF;
                    end
                    CLS_ILLEGAL: begin
                        w_illegal = 1'b1;
                        w_next    = S_IF;
                    end
                    default: begin
                        w_next = S_EX;
                    end
                endcase
            end
            S_EX: begin
                w_alu_op  = w_dec_alu_op;
                w_alu_src = w_dec_alu_src;
                if (w_dec_cls == CLS_BRANCH) begin
                    w_pc_write = w_dec_br_ne ? ~zero_i : zero_i;
                    w_pc_src   = PC_SRC_BRANCH;
                    w_next     = S_IF;
                end else if (w_dec_cls == CLS_LOAD || w_dec_cls == CLS_STORE) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_alu_op    = w_dec_alu_op;
                w_mem_read  = (w_dec_cls == CLS_LOAD);
                w_mem_write = (w_dec_cls != CLS_LOAD);
                if (dmem_ready_i) begin
                    w_next = (w_dec_cls == CLS_LOAD) ? S_WB : S_IF;
                end
            end
            S_WB: begin
                w_alu_op     = w_dec_alu_op;
                w_reg_write  = 1'b1;
                w_reg_dst    = w_dec_reg_dst;
                w_mem_to_reg = w_dec_mem_to_reg;
                w_next       = S_IF;
            end
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    // Outputs are combinational, so reset must mask them explicitly, not just reset the state.
    assign imem_read_o = rst_i & w_imem_read;
    assign IR_write_o  = rst_i & w_ir_write;
    assign PC_write_o  = rst_i & w_pc_write;
    assign PC_src_o    = rst_i ? w_pc_src : '0;
    assign ALUOp_o     = rst_i ? w_alu_op : '0;
    assign ALUSrc_o    = rst_i & w_alu_src;
    assign RegDst_o    = rst_i & w_reg_dst;
    assign RegWrite_o  = rst_i & w_reg_write;
    assign MemRead_o   = rst_i & w_mem_read;
    assign MemWrite_o  = rst_i & w_mem_write;
    assign MemtoReg_o  = rst_i & w_mem_to_reg;
    assign illegal_o   = rst_i & w_illegal;
    assign state_o     = r_state;

`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;
    logic        w_retire;

    // Every return to fetch retires an instruction, except the abort of an illegal opcode.
    assign w_retire = (r_state != S_IF) && (w_next == S_IF) && !w_illegal;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt_o   = r_cycle_cnt;
    assign instret_cnt_o = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Scoreboard bench for multicycle_main_ctrl: per-instruction expectations from a reference model.
module tb_multicycle_main_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic [5:0] op_i;
    logic       imem_ready_i;
    logic       dmem_ready_i;
    logic       zero_i;
    logic       imem_read_o;
    logic       IR_write_o;
    logic       PC_write_o;
    logic [1:0] PC_src_o;
    logic [2:0] ALUOp_o;
    logic       ALUSrc_o;
    logic       RegDst_o;
    logic       RegWrite_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       MemtoReg_o;
    logic       illegal_o;
    logic [2:0] state_o;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_o;
    logic [31:0] instret_cnt_o;
`endif

    multicycle_main_ctrl u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .imem_ready_i (imem_ready_i),
        .dmem_ready_i (dmem_ready_i),
        .zero_i       (zero_i),
        .imem_read_o  (imem_read_o),
        .IR_write_o   (IR_write_o),
        .PC_write_o   (PC_write_o),
        .PC_src_o     (PC_src_o),
        .ALUOp_o      (ALUOp_o),
        .ALUSrc_o     (ALUSrc_o),
        .RegDst_o     (RegDst_o),
        .RegWrite_o   (RegWrite_o),
        .MemRead_o    (MemRead_o),
        .MemWrite_o   (MemWrite_o),
        .MemtoReg_o   (MemtoReg_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
`ifdef MC_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_cnt_o (instret_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0] op;
        bit         zero;
        int         iw;
        int         dw;
    } stim_t;

    typedef struct {
        int cyc;
        int n_if, n_id, n_ex, n_mem, n_wb;
        int ir_w, pc_w, pc_src;
        int mr, mw, rw, ill;
        int aluop, alusrc, regdst, m2r;
    } rec_t;

    stim_t stim_q[$];
    rec_t  exp_q[$];

    // Reference model: what one instruction must look like, from the opcode table and ready waits.
    function automatic rec_t model(input stim_t s);
        rec_t r;
        int   aluop = 0;
        bit   is_r = 0, alu_i = 0, is_lw = 0, is_sw = 0, is_j = 0;
        bit   is_beq = 0, is_bne = 0, is_ill = 0, has_ex, has_mem, has_wb, taken;
        case (s.op)
            6'b000000: begin aluop = 0; is_r = 1; end
            6'b001000: begin aluop = 1; alu_i = 1; end
            6'b001011: begin aluop = 2; alu_i = 1; end
            6'b000100: begin aluop = 3; is_beq = 1; end
            6'b001111: begin aluop = 4; alu_i = 1; end
            6'b001101: begin aluop = 5; alu_i = 1; end
            6'b000101: begin aluop = 6; is_bne = 1; end
            6'b100011: begin aluop = 1; is_lw = 1; end
            6'b101011: begin aluop = 1; is_sw = 1; end
            6'b000010: is_j = 1;
            default:   is_ill = 1;
        endcase
        has_ex  = !(is_j || is_ill);
        has_mem = is_lw || is_sw;
        has_wb  = is_r || alu_i || is_lw;
        taken   = (is_beq && s.zero) || (is_bne && !s.zero);
        r.n_if   = s.iw + 1;
        r.n_id   = 1;
        r.n_ex   = int'(has_ex);
        r.n_mem  = has_mem ? s.dw + 1 : 0;
        r.n_wb   = int'(has_wb);
        r.cyc    = r.n_if + r.n_id + r.n_ex + r.n_mem + r.n_wb;
        r.ir_w   = 1;
        r.pc_w   = 1 + int'(is_j) + int'(taken);
        r.pc_src = is_j ? 2 : (taken ? 1 : 0);
        r.mr     = is_lw ? s.dw + 1 : 0;
        r.mw     = is_sw ? s.dw + 1 : 0;
        r.rw     = int'(has_wb);
        r.ill    = int'(is_ill);
        r.aluop  = has_ex ? aluop : 7;
        r.alusrc = int'(has_ex && (alu_i || is_lw || is_sw));
        r.regdst = int'(is_r);
        r.m2r    = int'(is_lw);
        return r;
    endfunction

    function automatic stim_t mk(input logic [5:0] op, input bit zero, input int iw, input int dw);
        stim_t s;
        s.op = op; s.zero = zero; s.iw = iw; s.dw = dw;
        return s;
    endfunction

    // ---------------- monitor ----------------
    bit   mon_en = 0;
    bit   m_active = 0;
    int   m_prev = 7;
    rec_t m_obs;
    int   m_hold_err, m_side_err;
    longint exp_cycles = 0;
    longint exp_ret = 0;

    task automatic finish_rec();
        rec_t e;
        if (exp_q.size() == 0) begin
            check("exp_available", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check("cycles",      m_obs.cyc,    e.cyc);
        check("n_if",        m_obs.n_if,   e.n_if);
        check("n_id",        m_obs.n_id,   e.n_id);
        check("n_ex",        m_obs.n_ex,   e.n_ex);
        check("n_mem",       m_obs.n_mem,  e.n_mem);
        check("n_wb",        m_obs.n_wb,   e.n_wb);
        check("ir_write",    m_obs.ir_w,   e.ir_w);
        check("pc_write",    m_obs.pc_w,   e.pc_w);
        check("pc_src",      m_obs.pc_src, e.pc_src);
        check("mem_read",    m_obs.mr,     e.mr);
        check("mem_write",   m_obs.mw,     e.mw);
        check("reg_write",   m_obs.rw,     e.rw);
        check("illegal",     m_obs.ill,    e.ill);
        check("aluop_ex",    m_obs.aluop,  e.aluop);
        check("alusrc_ex",   m_obs.alusrc, e.alusrc);
        check("regdst_wb",   m_obs.regdst, e.regdst);
        check("memtoreg_wb", m_obs.m2r,    e.m2r);
        check("aluop_hold",  m_hold_err,   0);
        check("side_rules",  m_side_err,   0);
`ifdef MC_CTRL_PERF_CNT_EN
        exp_cycles += e.cyc;
        exp_ret    += (e.ill == 0) ? 1 : 0;
        check("cycle_cnt",   cycle_cnt_o,   exp_cycles[31:0]);
        check("instret_cnt", instret_cnt_o, exp_ret[31:0]);
`endif
    endtask

    always @(negedge clk_i) begin
        int st;
        if (mon_en) begin
            st = int'(state_o);
            if (st == 0 && m_prev != 0) begin
                if (m_active) finish_rec();
                m_obs = '{default: 0};
                m_obs.aluop = 7;
                m_hold_err = 0;
                m_side_err = 0;
                m_active = 1;
            end
            m_obs.cyc++;
            case (st)
                0: m_obs.n_if++;
                1: m_obs.n_id++;
                2: m_obs.n_ex++;
                3: m_obs.n_mem++;
                4: m_obs.n_wb++;
                default: m_side_err++;
            endcase
            m_obs.ir_w += int'(IR_write_o);
            if (PC_write_o) begin
                m_obs.pc_w++;
                m_obs.pc_src = int'(PC_src_o);
            end
            m_obs.mr  += int'(MemRead_o);
            m_obs.mw  += int'(MemWrite_o);
            m_obs.rw  += int'(RegWrite_o);
            m_obs.ill += int'(illegal_o);
            if (st == 2) begin
                m_obs.aluop  = int'(ALUOp_o);
                m_obs.alusrc = int'(ALUSrc_o);
            end
            if (st == 4) begin
                m_obs.regdst = int'(RegDst_o);
                m_obs.m2r    = int'(MemtoReg_o);
            end
            if ((st == 3 || st == 4) && int'(ALUOp_o) != m_obs.aluop) m_hold_err++;
            if (st <= 1 && ALUOp_o != 3'b001) m_hold_err++;
            if (st != 2 && ALUSrc_o) m_side_err++;
            if (st != 4 && (RegDst_o || MemtoReg_o)) m_side_err++;
            if (MemWrite_o && RegWrite_o) m_side_err++;
            if ((st == 0) != imem_read_o) m_side_err++;
            m_prev = st;
        end
    end

    // ---------------- driver / memory responders ----------------
    stim_t cur;
    int    d_prev = 7;
    int    icnt = 0;
    int    dcnt = 0;

    task automatic cycle_start(output bit done);
        int st;
        st = int'(state_o);
        done = 0;
        if (st == 0 && d_prev != 0) begin
            if (stim_q.size() > 0) begin
                cur    = stim_q.pop_front();
                op_i   = cur.op;
                zero_i = cur.zero;
                exp_q.push_back(model(cur));
            end else begin
                done = 1;
            end
        end
        d_prev = st;
        if (imem_read_o) begin
            icnt++;
            imem_ready_i = !done && (icnt > cur.iw);
        end else begin
            icnt = 0;
            imem_ready_i = 1'b0;
        end
        if (MemRead_o || MemWrite_o) begin
            dcnt++;
            dmem_ready_i = (dcnt > cur.dw);
        end else begin
            dcnt = 0;
            dmem_ready_i = 1'b0;
        end
    endtask

    logic [17:0] out_vec;
    assign out_vec = {imem_read_o, IR_write_o, PC_write_o, PC_src_o, ALUOp_o, ALUSrc_o, RegDst_o,
                      RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, illegal_o, state_o};

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b001000, 6'b001011, 6'b000100, 6'b001111,
                                   6'b001101, 6'b000101, 6'b100011, 6'b101011, 6'b000010};

    initial begin
        bit done;
        bit found;
        logic [5:0] rop;
        rst_i = 1'b0;
        op_i = 6'h3f;
        imem_ready_i = 1'b1;
        dmem_ready_i = 1'b1;
        zero_i = 1'b1;

        // Directed instructions first, then randomized ones.
        stim_q.push_back(mk(6'b001000, 0, 0, 0));
        stim_q.push_back(mk(6'b000010, 0, 0, 0));
        stim_q.push_back(mk(6'b101011, 0, 0, 0));
        stim_q.push_back(mk(6'b000000, 0, 0, 0));
        stim_q.push_back(mk(6'b100011, 0, 0, 3));
        stim_q.push_back(mk(6'b000100, 1, 0, 0));
        stim_q.push_back(mk(6'b000101, 1, 0, 0));
        stim_q.push_back(mk(6'b111111, 0, 0, 0));
        stim_q.push_back(mk(6'b000100, 0, 2, 0));
        stim_q.push_back(mk(6'b000101, 0, 1, 0));
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) rop = 6'($urandom_range(0, 63));
            else rop = legal_ops[$urandom_range(0, 9)];
            stim_q.push_back(mk(rop, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outputs_zero", out_vec, 18'd0);
        check("reset_state", state_o, 3'd0);
`ifdef MC_CTRL_PERF_CNT_EN
        check("reset_cycle_cnt", cycle_cnt_o, 32'd0);
        check("reset_instret_cnt", instret_cnt_o, 32'd0);
`endif

        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        d_prev = 7;
        m_prev = 7;
        m_active = 0;
        mon_en = 1;
        #1;
        cycle_start(done);
        for (int c = 0; c < 20000 && !done; c++) begin
            @(posedge clk_i);
            #1;
            cycle_start(done);
        end
        if (!done) check("drain_timeout", 0, 1);
        @(negedge clk_i);
        #1;
        mon_en = 0;
        check("exp_q_drained", exp_q.size(), 0);

        // Reset during the MEM phase of a store must kill the write at once.
        op_i = 6'b101011;
        zero_i = 1'b0;
        dmem_ready_i = 1'b0;
        imem_ready_i = 1'b1;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk_i);
            #1;
            if (state_o == 3'd3) found = 1;
        end
        check("sw_reached_mem", found, 1);
        check("sw_mem_write_before_reset", MemWrite_o, 1);
        rst_i = 1'b0;
        #1;
        check("abort_mem_write", MemWrite_o, 0);
        check("abort_outputs_zero", out_vec, 18'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b1;
        #1;
        check("post_reset_state", state_o, 3'd0);
        check("post_reset_imem_read", imem_read_o, 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            check("post_reset_no_write", {MemWrite_o, RegWrite_o, state_o}, 5'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_main_ctrl.md
Name: multicycle_main_ctrl

Overview:
- Multicycle main control FSM that sequences each instruction through fetch, decode, execute, memory and writeback.
- Produces the 3-bit ALUOp code consumed by the ALU control decoder, plus datapath enables and memory request strobes.
- Sits between the instruction register and the datapath, and stalls on instruction-memory and data-memory ready handshakes.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, width of the ALUOp output.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- op_i  in  6  opcode from the instruction register (IR[31:26])
- imem_ready_i  in  1  instruction word valid this cycle
- dmem_ready_i  in  1  data access complete this cycle
- zero_i  in  1  ALU zero flag
- imem_read_o  out  1  instruction fetch request
- IR_write_o  out  1  load the IR
- PC_write_o  out  1  write the PC
- PC_src_o  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target
- ALUOp_o  out  3  ALUOp code to the ALU control decoder
- ALUSrc_o  out  1  1 selects the immediate operand
- RegDst_o  out  1  1 selects rd as destination, 0 selects rt
- RegWrite_o  out  1  register file write enable
- MemRead_o  out  1  data read request
- MemWrite_o  out  1  data write request
- MemtoReg_o  out  1  writeback value from memory
- illegal_o  out  1  one-cycle pulse on an unknown opcode
- state_o  out  3  current state, for debug

Behaviour:
- Reset:
  - While rst_i=0, state=S_IF and op_q=0; every output is forced 0, including imem_read_o.
  - When rst_i is released, fetch begins on the next edge.
  - Reset asserted mid-instruction aborts it: no pending RegWrite or MemWrite completes.
- State encoding: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4.
- S_IF:
  - imem_read_o=1.
  - If imem_ready_i=1: IR_write_o=1, PC_write_o=1, PC_src_o=00, next state S_ID.
  - Otherwise hold in S_IF with all write enables at 0.
- S_ID:
  - op_q <= op_i.
  - Decode the opcode:
    - 000000 R-type, ALUOp 000
    - 001000 addi, ALUOp 001
    - 001011 sltiu, ALUOp 010
    - 000100 beq, ALUOp 011
    - 001111 lui, ALUOp 100
    - 001101 ori, ALUOp 101
    - 000101 bne, ALUOp 110
    - 100011 lw, ALUOp 001
    - 101011 sw, ALUOp 001
    - 000010 j
  - j: PC_write_o=1, PC_src_o=10, next state S_IF.
  - Unknown opcode: illegal_o=1 for this cycle, next state S_IF; the PC has already advanced in S_IF.
  - All other opcodes: next state S_EX.
- S_EX:
  - ALUOp_o is the decoded code of op_q.
  - ALUSrc_o=1 for addi, sltiu, lui, ori, lw and sw; 0 for all others.
  - beq: PC_write_o=zero_i. bne: PC_write_o=~zero_i. For both, PC_src_o=01 and next state S_IF.
  - lw and sw: next state S_MEM. All others: next state S_WB.
- S_MEM:
  - lw: MemRead_o=1. sw: MemWrite_o=1.
  - The request is held until dmem_ready_i=1.
  - On ready: lw goes to S_WB, sw goes to S_IF.
- S_WB:
  - RegWrite_o=1 for exactly one cycle, next state S_IF.
  - RegDst_o=1 only for R-type.
  - MemtoReg_o=1 only for lw.
- ALUOp_o holds the decoded value from S_EX through S_WB. In S_IF and S_ID it is 001.
- Outputs are combinational from state, op_q and the ready/zero inputs. No output is registered.
- Minimum latency with ready inputs tied to 1:
  - j: 2 cycles
  - beq/bne: 3 cycles
  - R-type and I-type ALU instructions: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
- Each wait cycle on a ready input adds exactly one cycle.
- MemWrite_o and RegWrite_o are never asserted in the same cycle.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- When defined:
  - Adds a 32-bit cycle_cnt_o (increments every cycle out of reset).
  - Adds a 32-bit instret_cnt_o (increments on every transition into S_IF from another state; illegal opcodes excluded).
  - Both counters reset to 0 and wrap modulo 2^32.
- When undefined: neither port nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg:
  - Opcode constants.
  - ALUOp constants (ALUOP_RTYPE=000 through ALUOP_BNE=110).
  - State encoding constants.
  - PC_src encodings.
- One sub-module, mc_op_decode, purely combinational:
  - Inputs: op_q.
  - Outputs: ALUOp, ALUSrc, RegDst, MemtoReg, instruction class (alu, branch, load, store, jump, illegal).
- The FSM instantiates mc_op_decode once.

Test Plan:
- Reset released, imem_ready_i=1, op_i=000000 -> state_o sequence 0,1,2,4,0; ALUOp_o=000 in EX; RegWrite_o=1 and RegDst_o=1 only in WB.
- lw (100011) with dmem_ready_i low for 3 cycles -> MemRead_o high for 4 cycles, then S_WB with MemtoReg_o=1; total 8 cycles.
- beq with zero_i=1 -> PC_write_o=1 with PC_src_o=01 in EX. bne with zero_i=1 -> PC_write_o=0 in EX. Both are 3 cycles.
- op_i=111111 -> illegal_o pulses for 1 cycle in ID; next state S_IF; no RegWrite_o, MemRead_o or MemWrite_o.
- rst_i dropped during S_MEM of sw -> MemWrite_o=0 immediately; after release state_o=0 and imem_read_o=1.
- With MC_CTRL_PERF_CNT_EN: addi, j, sw back-to-back (all ready inputs tied to 1) -> instret_cnt_o=3, cycle_cnt_o=10.
